// File: rtl/encoder_rr_if.sv
`default_nettype none
// ============================================================================
// Module      : encoder_rr_if
// Description : Request/index handshake bundle for the round-robin encoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface encoder_rr_if #(
    parameter int N = 4
);
    localparam int W = $clog2(N);

    logic         ena;
    logic [N-1:0] req;
    logic         out_ready;
    logic [W-1:0] out;
    logic         out_valid;

    modport master (
        output ena,
        output req,
        output out_ready,
        input  out,
        input  out_valid
    );

    modport slave (
        input  ena,
        input  req,
        input  out_ready,
        output out,
        output out_valid
    );
endinterface
`default_nettype wire

// File: rtl/encoder_rr.sv
`default_nettype none
// ============================================================================
// Module      : encoder_rr
// Description : Registered round-robin N-to-binary encoder with valid/ready out.
// Revision    : 1.0 - initial release
// ============================================================================
module encoder_rr #(
    parameter int N = 4
) (
    input  wire logic    clk,
    input  wire logic    rst,
    encoder_rr_if.slave  bus
);
    localparam int           W      = $clog2(N);
    localparam logic [N-1:0] C_ONES = '1;
    localparam logic [W-1:0] C_LAST = W'(N - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t       r_state;
    logic [W-1:0] r_ptr;
    logic [W-1:0] r_out;
    logic         r_valid;

    logic [N-1:0] w_hi;
    logic         w_found;
    logic [W-1:0] w_sel;
    logic         w_load;
    logic [W-1:0] w_ptr_next;

    // Index of the lowest set bit; descending scan so the lowest wins.
    function automatic logic [W-1:0] f_lowest(input logic [N-1:0] v);
        logic [W-1:0] idx;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) idx = W'(i);
        end
        return idx;
    endfunction

    // Rotating priority: requests at or above ptr win; otherwise wrap to the
    // lowest request below ptr.
    always_comb begin
        w_hi       = bus.req & (C_ONES << r_ptr);
        w_found    = |bus.req;
        w_sel      = (|w_hi) ? f_lowest(w_hi) : f_lowest(bus.req);
        w_load     = bus.ena && w_found && (!r_valid || bus.out_ready);
        w_ptr_next = (w_sel == C_LAST) ? '0 : w_sel + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_out   <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_load) begin
                        r_out   <= w_sel;
                        r_ptr   <= w_ptr_next;
                        r_valid <= 1'b1;
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    // Accept and reload on the same edge keeps out_valid high.
                    if (w_load) begin
                        r_out   <= w_sel;
                        r_ptr   <= w_ptr_next;
                        r_valid <= 1'b1;
                        r_state <= S_HOLD;
                    end else if (bus.out_ready) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.out       = r_out;
    assign bus.out_valid = r_valid;
endmodule
`default_nettype wire

// File: tb/tb_encoder_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_encoder_rr
// Description : Self-checking bench for encoder_rr at N=4 and N=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_encoder_rr;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    encoder_rr_if #(.N(4)) bus4 ();
    encoder_rr_if #(.N(3)) bus3 ();

    encoder_rr #(.N(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    encoder_rr #(.N(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    // Index must stay frozen while it waits for acceptance.
    a_hold4: assert property (@(posedge clk) disable iff (rst)
        (bus4.out_valid && !bus4.out_ready) |=> (bus4.out == $past(bus4.out)))
        else begin
            failures++;
            $display("FAIL hold_stable_n4 out=%0d required=%0d", bus4.out, $past(bus4.out));
        end

    a_hold3: assert property (@(posedge clk) disable iff (rst)
        (bus3.out_valid && !bus3.out_ready) |=> (bus3.out == $past(bus3.out)))
        else begin
            failures++;
            $display("FAIL hold_stable_n3 out=%0d required=%0d", bus3.out, $past(bus3.out));
        end

    // Reference model: index 0 is the N=4 instance, index 1 the N=3 instance.
    int m_out[2];
    int m_valid[2];
    int m_ptr[2];

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_out[k] = 0; m_valid[k] = 0; m_ptr[k] = 0;
        end
    endfunction

    function automatic void model_step(int k, int n, logic ena, logic [3:0] req, logic rdy);
        bit found = 0;
        int pick  = 0;
        for (int off = 0; off < n; off++) begin
            int idx = (m_ptr[k] + off) % n;
            if (!found && req[idx]) begin
                found = 1;
                pick  = idx;
            end
        end
        if (ena && found && (m_valid[k] == 0 || rdy)) begin
            m_out[k]   = pick;
            m_valid[k] = 1;
            m_ptr[k]   = (pick + 1) % n;
        end else if (m_valid[k] == 1 && rdy) begin
            m_valid[k] = 0;
        end
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic cycle();
        model_step(0, 4, bus4.ena, bus4.req, bus4.out_ready);
        model_step(1, 3, bus3.ena, {1'b0, bus3.req}, bus3.out_ready);
        @(posedge clk);
        #1;
    endtask

    task automatic drive4(logic ena, logic [3:0] req, logic rdy);
        bus4.ena = ena; bus4.req = req; bus4.out_ready = rdy;
    endtask

    task automatic drive3(logic ena, logic [2:0] req, logic rdy);
        bus3.ena = ena; bus3.req = req; bus3.out_ready = rdy;
    endtask

    typedef struct {
        logic       ena;
        logic [3:0] req;
        logic       rdy;
        int         exp_out;
        logic       exp_valid;
    } vec_t;

    vec_t tbl[26];

    initial begin
        // fairness from reset
        tbl[0]  = '{1'b1, 4'b1111, 1'b1, 0, 1'b1};
        tbl[1]  = '{1'b1, 4'b1111, 1'b1, 1, 1'b1};
        tbl[2]  = '{1'b1, 4'b1111, 1'b1, 2, 1'b1};
        tbl[3]  = '{1'b1, 4'b1111, 1'b1, 3, 1'b1};
        tbl[4]  = '{1'b1, 4'b1111, 1'b1, 0, 1'b1};
        tbl[5]  = '{1'b1, 4'b0000, 1'b1, 0, 1'b0};
        // single request
        tbl[6]  = '{1'b1, 4'b0100, 1'b1, 2, 1'b1};
        tbl[7]  = '{1'b1, 4'b0000, 1'b1, 2, 1'b0};
        // backpressure
        tbl[8]  = '{1'b1, 4'b0010, 1'b0, 1, 1'b1};
        tbl[9]  = '{1'b1, 4'b1000, 1'b0, 1, 1'b1};
        tbl[10] = '{1'b1, 4'b1000, 1'b0, 1, 1'b1};
        tbl[11] = '{1'b1, 4'b1000, 1'b0, 1, 1'b1};
        tbl[12] = '{1'b1, 4'b1000, 1'b1, 3, 1'b1};
        tbl[13] = '{1'b1, 4'b0000, 1'b1, 3, 1'b0};
        // enable low blocks loads but not accepts
        tbl[14] = '{1'b0, 4'b1111, 1'b1, 3, 1'b0};
        tbl[15] = '{1'b0, 4'b1111, 1'b1, 3, 1'b0};
        tbl[16] = '{1'b0, 4'b1111, 1'b1, 3, 1'b0};
        tbl[17] = '{1'b0, 4'b1111, 1'b1, 3, 1'b0};
        tbl[18] = '{1'b0, 4'b1111, 1'b1, 3, 1'b0};
        tbl[19] = '{1'b1, 4'b0010, 1'b0, 1, 1'b1};
        tbl[20] = '{1'b0, 4'b1111, 1'b1, 1, 1'b0};
        tbl[21] = '{1'b0, 4'b1111, 1'b1, 1, 1'b0};
        // wrap
        tbl[22] = '{1'b1, 4'b0100, 1'b1, 2, 1'b1};
        tbl[23] = '{1'b1, 4'b0101, 1'b1, 0, 1'b1};
        tbl[24] = '{1'b1, 4'b0101, 1'b1, 2, 1'b1};
        tbl[25] = '{1'b1, 4'b0000, 1'b1, 2, 1'b0};

        drive4(1'b0, 4'b0000, 1'b0);
        drive3(1'b0, 3'b000, 1'b0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", int'(bus4.out), 0);
        check("reset_valid", int'(bus4.out_valid), 0);
        rst = 1'b0;

        for (int i = 0; i < 26; i++) begin
            drive4(tbl[i].ena, tbl[i].req, tbl[i].rdy);
            cycle();
            check($sformatf("vec%0d_out", i), int'(bus4.out), tbl[i].exp_out);
            check($sformatf("vec%0d_valid", i), int'(bus4.out_valid), int'(tbl[i].exp_valid));
        end

        // asynchronous reset while an index is pending
        drive4(1'b1, 4'b0100, 1'b0);
        cycle();
        check("pre_rst_out", int'(bus4.out), 2);
        check("pre_rst_valid", int'(bus4.out_valid), 1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("async_rst_out", int'(bus4.out), 0);
        check("async_rst_valid", int'(bus4.out_valid), 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        drive4(1'b1, 4'b1111, 1'b1);
        cycle();
        check("post_rst_first_out", int'(bus4.out), 0);
        check("post_rst_first_valid", int'(bus4.out_valid), 1);

        // N=3 wrap: 0,1,2,0 and never 3
        drive4(1'b0, 4'b0000, 1'b1);
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        drive3(1'b1, 3'b111, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check($sformatf("n3_wrap%0d_out", i), int'(bus3.out), (i == 3) ? 0 : i);
            check($sformatf("n3_wrap%0d_valid", i), int'(bus3.out_valid), 1);
        end

        // randomized traffic on both instances against the model
        drive3(1'b0, 3'b000, 1'b1);
        cycle();
        for (int i = 0; i < 400; i++) begin
            drive4($urandom_range(0, 3) != 0,
                   ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom_range(0, 15)),
                   $urandom_range(0, 2) != 0);
            drive3($urandom_range(0, 3) != 0,
                   ($urandom_range(0, 4) == 0) ? 3'b000 : 3'($urandom_range(0, 7)),
                   $urandom_range(0, 2) != 0);
            cycle();
            check("rand_n4_valid", int'(bus4.out_valid), m_valid[0]);
            if (m_valid[0] == 1) check("rand_n4_out", int'(bus4.out), m_out[0]);
            check("rand_n3_valid", int'(bus3.out_valid), m_valid[1]);
            if (m_valid[1] == 1) check("rand_n3_out", int'(bus3.out), m_out[1]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/encoder_rr.md
# encoder_rr

Registered round-robin N-to-binary encoder, the encoding counterpart to the team's enabled decoders. Samples a vector of request lines and emits the binary index of one asserted line per transfer, with rotating priority and a valid/ready output handshake. Sits in front of any consumer that needs a fair, stable binary index: register-file port select, interrupt source ID, or a decoder that turns the index back into one-hot.

## Interface
- N, default 4: number of request lines, N >= 2 (need not be a power of two).
- W, default $clog2(N): index width, derived and never overridden.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ena  in  1  enable; when low, no new index is captured.
- req  in  N  request lines, level-sensitive; bit i requests index i.
- out_ready  in  1  consumer accepts out this cycle.
- out  out  W  registered binary index of the granted line.
- out_valid  out  1  out holds an unaccepted index.

## Operation
- State: IDLE (out_valid=0) and HOLD (out_valid=1). Internal priority pointer ptr, W bits, range 0..N-1.
- Selection (combinational): sel = first set bit of req scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1. found = |req.
- Load condition: load = ena && found && (!out_valid || out_ready).
- On load: out <= sel; out_valid <= 1; ptr <= (sel == N-1) ? 0 : sel+1. The state is HOLD.
- In HOLD with out_ready=1 and no load: out_valid <= 0, go IDLE; out and ptr keep their values.
- In HOLD with out_ready=0: out, out_valid, ptr frozen. req and ena changes are ignored until accept.
- Transfer occurs on any edge where out_valid && out_ready.
- ena=0 never drops a pending output. It only blocks new loads.
- Requests are not latched or cleared by the block. A line still high after its grant competes again at lowest priority.
- Indices >= N are never produced. Bits of req above N-1 do not exist.

## Timing
- Reset (async, immediate): out=0, out_valid=0, ptr=0, state IDLE. Held while rst=1.
- Reset mid-HOLD discards the pending index. The first post-reset grant scans from index 0.
- Latency: req/ena sampled at edge k gives out/out_valid valid after edge k. Index visible the cycle after request is presented.
- Throughput: one index per cycle when out_ready=1 and requests are continuous (accept and reload on the same edge).
- Simultaneous accept + load: the new index replaces the old on the same edge, with no bubble. out_valid stays 1.
- Simultaneous accept + no request (or ena=0): out_valid falls on that edge.
- Wrap: ptr after granting N-1 is 0. With non-power-of-two N, ptr never reaches N.
- Zero requests with ena=1: no load, out_valid unaffected except by accept.
- out must not change while out_valid=1 and out_ready=0. This is a hard requirement and must be asserted in the bench.

## Test plan
- Reset: assert rst asynchronously mid-HOLD (out=2, out_valid=1) -> out=0, out_valid=0 before the next edge. After release, req=4'b1111 grants 0 first.
- Single request: N=4, ena=1, out_ready=1, req=4'b0100 for one cycle -> after one edge out=2, out_valid=1. Next edge out_valid=0.
- Fairness: req=4'b1111 held, out_ready=1, from reset -> out sequence 0,1,2,3,0 on consecutive cycles, out_valid continuously 1.
- Backpressure: req=4'b0010 -> out=1. Hold out_ready=0 for 3 cycles while req changes to 4'b1000 -> out stays 1, valid stays 1. Raise out_ready -> next edge out=3.
- Enable: ena=0, req=4'b1111 for 5 cycles -> out_valid stays 0. Grant pending (out=1, out_ready=0), drop ena, then accept -> out_valid=0 next edge, no new grant.
- Wrap: grant 2 (ptr=3), then req=4'b0101, out_ready=1 -> out=0, then out=2. Repeat with N=3 and req=3'b111 -> 0,1,2,0; out never reaches 3.
